// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scan controller.
//   FIRST_COLUMN  column drive pattern for column index 0
//   wait_state_t  states of the wait-for-key sequencer
//   key_of()      (column index, row bit) -> key index
//   lsb4()        index of the lowest set bit in a 4-bit vector
package keypad_pkg;

  localparam logic [3:0] FIRST_COLUMN = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HOLD,
    DONE
  } wait_state_t;

  // row_bit + 4*(3-col); for a 2-bit col, 3-col is just ~col
  function automatic logic [3:0] key_of(input logic [1:0] col, input logic [1:0] row_bit);
    return {~col, row_bit};
  endfunction

  // Returns 3 for an all-zero input; callers only use it when some bit is set
  function automatic logic [1:0] lsb4(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: debounce state for a single key.
//   clk, rst   clock, asynchronous active-high reset
//   sample_en  high on the cycle this key's column is sampled
//   raw        sampled key state, 1 = closed
//   stable     debounced key state
//   rise/fall  high on the sample cycle where stable is about to flip 0->1 / 1->0
module keypad_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_SCANS - 1);

  logic [CW-1:0] r_cnt;
  logic          r_stable;
  logic          w_flip;

  assign w_flip = sample_en && (raw != r_stable) && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (sample_en) begin
      if (raw == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_stable <= raw;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;
  assign rise   = w_flip & raw;
  assign fall   = w_flip & ~raw;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column scanner, 16-key debouncer and wait-for-key sequencer.
//   clk, rst       clock, asynchronous active-high reset
//   column         one-hot column drive (4'b1000 >> column index)
//   row            active-low row sense
//   keys           debounced key bitmap, 1 = pressed
//   query_key      key index to look up; query_pressed is keys[query_key] one cycle later
//   wait_req       starts a press-then-release wait when sampled in IDLE
//   wait_cancel    aborts a wait in progress without a completion pulse
//   waiting        high while a wait is in progress (ARMED/HOLD/DONE)
//   key_valid      one-cycle completion pulse
//   key_index      key that completed the most recent wait
//
// Wait FSM
//   state | meaning
//   IDLE  | no wait in progress
//   ARMED | waiting for any key to become pressed (already-held keys ignored)
//   HOLD  | captured key pressed, waiting for it to be released
//   DONE  | completion cycle, key_valid high
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  column,
  input  logic [3:0]  row,
  output logic [15:0] keys,
  input  logic [3:0]  query_key,
  output logic        query_pressed,
  input  logic        wait_req,
  input  logic        wait_cancel,
  output logic        waiting,
  output logic        key_valid,
  output logic [3:0]  key_index
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  logic [SW-1:0] r_settle;
  logic [1:0]    r_col;
  logic          w_tc;

  assign w_tc = (r_settle == SETTLE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle <= '0;
      r_col    <= 2'd0;
    end else if (w_tc) begin
      r_settle <= '0;
      r_col    <= r_col + 2'd1;
    end else begin
      r_settle <= r_settle + 1'b1;
    end
  end

  assign column = FIRST_COLUMN >> r_col;

  logic [15:0] w_stable;
  logic [15:0] w_rise;
  logic [15:0] w_fall;

  for (genvar k = 0; k < 16; k++) begin : g_key
    localparam logic [1:0] KCOL = 2'(3 - k / 4);
    localparam int         KROW = k % 4;
    logic w_sample;
    assign w_sample = w_tc && (r_col == KCOL);
    keypad_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_db (
      .clk      (clk),
      .rst      (rst),
      .sample_en(w_sample),
      .raw      (~row[KROW]),
      .stable   (w_stable[k]),
      .rise     (w_rise[k]),
      .fall     (w_fall[k])
    );
  end

  assign keys = w_stable;

  logic r_query_pressed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_query_pressed <= 1'b0;
    else     r_query_pressed <= w_stable[query_key];
  end

  assign query_pressed = r_query_pressed;

  wait_state_t r_state, w_next;
  logic [3:0]  r_cap, w_cap_next;
  logic [3:0]  r_key_index, w_key_index_next;
  logic [3:0]  w_rise_nib;

  // Strobes only fire for keys of the column being sampled, so the rising
  // keys all sit in that column's nibble and the lowest row bit is the
  // lowest key index.
  assign w_rise_nib = w_rise[{~r_col, 2'b00} +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cap       <= 4'd0;
      r_key_index <= 4'd0;
    end else begin
      r_state     <= w_next;
      r_cap       <= w_cap_next;
      r_key_index <= w_key_index_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    w_cap_next       = r_cap;
    w_key_index_next = r_key_index;
    case (r_state)
      IDLE: begin
        if (wait_req) w_next = ARMED;
      end
      ARMED: begin
        if (wait_cancel) begin
          w_next = IDLE;
        end else if (|w_rise) begin
          w_cap_next = key_of(r_col, lsb4(w_rise_nib));
          w_next     = HOLD;
        end
      end
      HOLD: begin
        if (wait_cancel) begin
          w_next = IDLE;
        end else if (w_fall[r_cap]) begin
          w_key_index_next = r_cap;
          w_next           = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign waiting   = (r_state != IDLE);
  assign key_valid = (r_state == DONE);
  assign key_index = r_key_index;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

  localparam int SETTLE = 4;
  localparam int DB     = 2;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_HOLD  = 2;
  localparam int M_DONE  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  column;
  logic [3:0]  row;
  logic [15:0] keys;
  logic [3:0]  query_key;
  logic        query_pressed;
  logic        wait_req;
  logic        wait_cancel;
  logic        waiting;
  logic        key_valid;
  logic [3:0]  key_index;

  keypad_scan_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .column       (column),
    .row          (row),
    .keys         (keys),
    .query_key    (query_key),
    .query_pressed(query_pressed),
    .wait_req     (wait_req),
    .wait_cancel  (wait_cancel),
    .waiting      (waiting),
    .key_valid    (key_valid),
    .key_index    (key_index)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  // Reference model: cycles since reset, per-key stable state and count of
  // consecutive disagreeing samples, and the phase of the wait service.
  int          m_n;
  bit [15:0]   m_stable;
  int          m_cnt[16];
  int          m_mode;
  int          m_cap;
  bit [3:0]    m_kidx;
  bit          m_qp;

  task automatic model_reset();
    m_n      = 0;
    m_stable = '0;
    for (int k = 0; k < 16; k++) m_cnt[k] = 0;
    m_mode   = M_IDLE;
    m_cap    = 0;
    m_kidx   = 4'd0;
    m_qp     = 1'b0;
  endtask

  // One clock edge of the specified behaviour, given the inputs held over it.
  task automatic model_edge(input bit [3:0] row_in, input bit [3:0] qk, input bit wr, input bit wc);
    bit [15:0] rises;
    bit [15:0] falls;
    int        c;
    int        k;
    int        lowest;
    bit        raw;
    rises = '0;
    falls = '0;
    m_qp  = m_stable[qk];
    if (m_n % SETTLE == SETTLE - 1) begin
      c = (m_n / SETTLE) % 4;
      for (int i = 0; i < 4; i++) begin
        k   = i + 4 * (3 - c);
        raw = ~row_in[i];
        if (raw == m_stable[k]) begin
          m_cnt[k] = 0;
        end else if (m_cnt[k] + 1 >= DB) begin
          m_stable[k] = raw;
          m_cnt[k]    = 0;
          if (raw) rises[k] = 1'b1;
          else     falls[k] = 1'b1;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
    m_n = m_n + 1;
    case (m_mode)
      M_IDLE:  if (wr) m_mode = M_ARMED;
      M_ARMED: begin
        if (wc) m_mode = M_IDLE;
        else if (rises != 0) begin
          lowest = -1;
          for (int j = 15; j >= 0; j--) if (rises[j]) lowest = j;
          m_cap  = lowest;
          m_mode = M_HOLD;
        end
      end
      M_HOLD: begin
        if (wc) m_mode = M_IDLE;
        else if (falls[m_cap]) begin
          m_kidx = 4'(m_cap);
          m_mode = M_DONE;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [3:0] ec;
    ec = 4'b1000;
    ec = ec >> ((m_n / SETTLE) % 4);
    chk("column", {12'd0, column}, {12'd0, ec});
    chk("keys", keys, m_stable);
    chk("query_pressed", {15'd0, query_pressed}, {15'd0, m_qp});
    chk("waiting", {15'd0, waiting}, {15'd0, m_mode != M_IDLE});
    chk("key_valid", {15'd0, key_valid}, {15'd0, m_mode == M_DONE});
    chk("key_index", {12'd0, key_index}, {12'd0, m_kidx});
  endtask

  // Drive one cycle from the set of physically closed keys, advance the
  // model across the edge, then compare at the following falling edge.
  task automatic cycle(input bit [15:0] mask, input bit wr, input bit wc, input bit [3:0] qk);
    bit [3:0] row_v;
    int       c;
    c = (m_n / SETTLE) % 4;
    for (int i = 0; i < 4; i++) row_v[i] = ~mask[i + 4 * (3 - c)];
    row         = row_v;
    wait_req    = wr;
    wait_cancel = wc;
    query_key   = qk;
    model_edge(row_v, qk, wr, wc);
    @(posedge clk);
    @(negedge clk);
    check_all();
    if (key_valid === 1'b1) pulses++;
  endtask

  typedef struct {
    bit [15:0] mask;
    bit        wr;
    bit        wc;
    bit [3:0]  qk;
    int        ncyc;
    bit [15:0] exp_keys;
    bit        exp_wait;
    int        exp_pulses;
    bit [3:0]  exp_idx;
    bit        exp_qp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    bit [15:0] rmask;

    // mask, wait_req pulse, cancel pulse, query_key, cycles | keys, waiting, pulses, key_index, query_pressed
    tbl[0]  = '{16'h0000, 1'b0, 1'b0, 4'hF, 32, 16'h0000, 1'b0, 0, 4'h0, 1'b0};
    tbl[1]  = '{16'h0400, 1'b1, 1'b0, 4'hF, 32, 16'h0400, 1'b1, 0, 4'h0, 1'b0};
    tbl[2]  = '{16'h0000, 1'b0, 1'b0, 4'hF, 32, 16'h0000, 1'b0, 1, 4'hA, 1'b0};
    tbl[3]  = '{16'h0020, 1'b0, 1'b0, 4'h5, 32, 16'h0020, 1'b0, 0, 4'hA, 1'b1};
    tbl[4]  = '{16'h0020, 1'b0, 1'b0, 4'h6, 32, 16'h0020, 1'b0, 0, 4'hA, 1'b0};
    tbl[5]  = '{16'h0008, 1'b0, 1'b0, 4'hF, 32, 16'h0008, 1'b0, 0, 4'hA, 1'b0};
    tbl[6]  = '{16'h0088, 1'b1, 1'b0, 4'hF, 32, 16'h0088, 1'b1, 0, 4'hA, 1'b0};
    tbl[7]  = '{16'h0000, 1'b0, 1'b0, 4'hF, 32, 16'h0000, 1'b0, 1, 4'h7, 1'b0};
    tbl[8]  = '{16'h0001, 1'b1, 1'b0, 4'hF, 32, 16'h0001, 1'b1, 0, 4'h7, 1'b0};
    tbl[9]  = '{16'h0001, 1'b0, 1'b1, 4'hF, 16, 16'h0001, 1'b0, 0, 4'h7, 1'b0};
    tbl[10] = '{16'h0000, 1'b0, 1'b0, 4'hF, 32, 16'h0000, 1'b0, 0, 4'h7, 1'b0};
    tbl[11] = '{16'h0400, 1'b0, 1'b0, 4'hF, 16, 16'h0000, 1'b0, 0, 4'h7, 1'b0};
    tbl[12] = '{16'h0000, 1'b0, 1'b0, 4'hF, 32, 16'h0000, 1'b0, 0, 4'h7, 1'b0};
    tbl[13] = '{16'h0400, 1'b1, 1'b0, 4'hF, 32, 16'h0400, 1'b1, 0, 4'h7, 1'b0};

    rst         = 1'b1;
    row         = 4'hF;
    query_key   = 4'd0;
    wait_req    = 1'b0;
    wait_cancel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all();

    for (int v = 0; v < 14; v++) begin
      pulses = 0;
      for (int j = 0; j < tbl[v].ncyc; j++)
        cycle(tbl[v].mask, tbl[v].wr && (j == 0), tbl[v].wc && (j == 0), tbl[v].qk);
      chk($sformatf("vec%0d keys", v), keys, tbl[v].exp_keys);
      chk($sformatf("vec%0d waiting", v), {15'd0, waiting}, {15'd0, tbl[v].exp_wait});
      chk($sformatf("vec%0d pulses", v), 16'(pulses), 16'(tbl[v].exp_pulses));
      chk($sformatf("vec%0d key_index", v), {12'd0, key_index}, {12'd0, tbl[v].exp_idx});
      chk($sformatf("vec%0d query_pressed", v), {15'd0, query_pressed}, {15'd0, tbl[v].exp_qp});
    end

    // Asynchronous reset while HOLD is active: outputs clear before any edge.
    #2 rst = 1'b1;
    #1;
    chk("async column", {12'd0, column}, 16'h0008);
    chk("async keys", keys, 16'h0000);
    chk("async waiting", {15'd0, waiting}, 16'h0000);
    chk("async key_valid", {15'd0, key_valid}, 16'h0000);
    row = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all();
    pulses = 0;
    for (int j = 0; j < 48; j++) cycle(16'h0000, 1'b0, 1'b0, 4'hA);
    chk("post-reset pulses", 16'(pulses), 16'd0);

    // Randomized: sparse key sets held for tens of cycles, random wait requests,
    // occasional cancels, random queries; every cycle compared with the model.
    rmask = 16'h0000;
    for (int j = 0; j < 1200; j++) begin
      if ($urandom_range(0, 39) == 0) rmask = 16'($urandom & $urandom & $urandom);
      cycle(rmask, $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
